// File: rtl/issue_round_sequencer.sv
// Steps a same-size convolution over the image in rounds of up to NUM_ALLOC output pixels,
// owning IssueBroadcast's reset and waiting for its done and for the allocators to drain.
module issue_round_sequencer #(
  parameter int unsigned NUM_ALLOC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_cfg_dim,
  input  logic [2:0]  i_cfg_filter,
  input  logic [8:0]  i_cfg_z_max,
  input  logic        i_bcast_done,
  input  logic        i_alloc_idle,
  output logic        o_bcast_rst,
  output logic [1:0]  o_image_padding,
  output logic [7:0]  o_x_min,
  output logic [7:0]  o_x_max,
  output logic [7:0]  o_x_start,
  output logic [7:0]  o_x_end,
  output logic [7:0]  o_y_min,
  output logic [7:0]  o_y_max,
  output logic [8:0]  o_z_max,
  output logic [4:0]  o_round_len,
  output logic [15:0] o_round_idx,
  output logic        o_busy,
  output logic        o_seq_done,
  output logic        o_cfg_err
);

  typedef enum logic [2:0] {
    StIdle, StLoad, StKick, StRun, StDrain, StNext, StFin
  } state_e;

  localparam logic [4:0]  NumAlloc5  = 5'(NUM_ALLOC);
  localparam logic [8:0]  NumAlloc9  = 9'(NUM_ALLOC);
  localparam logic [15:0] NumAlloc16 = 16'(NUM_ALLOC);

  state_e      r_state_q, r_state_d;
  logic [7:0]  r_dim_q, r_dim_d;
  logic [1:0]  r_pad_q, r_pad_d;
  logic [15:0] r_area_q, r_area_d;
  logic [15:0] r_idx_q, r_idx_d;
  logic [7:0]  r_sx_q, r_sx_d;
  logic [7:0]  r_sy_q, r_sy_d;
  logic [7:0]  r_x_max_q, r_x_max_d;
  logic [7:0]  r_x_start_q, r_x_start_d;
  logic [7:0]  r_x_end_q, r_x_end_d;
  logic [7:0]  r_y_min_q, r_y_min_d;
  logic [7:0]  r_y_max_q, r_y_max_d;
  logic [8:0]  r_z_max_q, r_z_max_d;
  logic [4:0]  r_len_q, r_len_d;
  logic [15:0] r_round_idx_q, r_round_idx_d;
  logic        r_bcast_rst_q, r_bcast_rst_d;
  logic        r_busy_q, r_busy_d;
  logic        r_seq_done_q, r_seq_done_d;
  logic        r_cfg_err_q, r_cfg_err_d;

  // Configuration check on the raw inputs
  logic       w_filter_ok;
  logic [1:0] w_pad;
  logic [8:0] w_span;
  logic       w_cfg_ok;

  always_comb begin
    w_filter_ok = 1'b1;
    w_pad       = 2'd0;
    case (i_cfg_filter)
      3'd1:    w_pad = 2'd0;
      3'd3:    w_pad = 2'd1;
      3'd5:    w_pad = 2'd2;
      default: w_filter_ok = 1'b0;
    endcase
  end

  assign w_span   = {1'b0, i_cfg_dim} + {6'd0, w_pad, 1'b0};
  assign w_cfg_ok = w_filter_ok && (NumAlloc9 <= {1'b0, i_cfg_dim}) && (w_span <= 9'd256);

  // Round geometry from the current start position
  logic [15:0] w_rem;
  logic [4:0]  w_len;
  logic [8:0]  w_ex_raw;
  logic        w_ex_wrap;
  logic [7:0]  w_ex;
  logic [7:0]  w_ey;
  logic [7:0]  w_pad2;
  logic [8:0]  w_sx_raw;
  logic        w_sx_wrap;
  logic [7:0]  w_sx_nx;
  logic [15:0] w_idx_nx;

  assign w_pad2    = {5'd0, r_pad_q, 1'b0};
  assign w_rem     = r_area_q - r_idx_q;
  assign w_len     = (w_rem < NumAlloc16) ? w_rem[4:0] : NumAlloc5;
  assign w_ex_raw  = {1'b0, r_sx_q} + {4'd0, w_len} - 9'd1;
  assign w_ex_wrap = (w_ex_raw >= {1'b0, r_dim_q});
  assign w_ex      = w_ex_wrap ? 8'(w_ex_raw - {1'b0, r_dim_q}) : w_ex_raw[7:0];
  assign w_ey      = r_sy_q + {7'd0, w_ex_wrap};
  assign w_sx_raw  = {1'b0, r_sx_q} + NumAlloc9;
  assign w_sx_wrap = (w_sx_raw >= {1'b0, r_dim_q});
  assign w_sx_nx   = w_sx_wrap ? 8'(w_sx_raw - {1'b0, r_dim_q}) : w_sx_raw[7:0];
  assign w_idx_nx  = r_idx_q + {11'd0, r_len_q};

  always_comb begin
    r_state_d     = r_state_q;
    r_dim_d       = r_dim_q;
    r_pad_d       = r_pad_q;
    r_area_d      = r_area_q;
    r_idx_d       = r_idx_q;
    r_sx_d        = r_sx_q;
    r_sy_d        = r_sy_q;
    r_x_max_d     = r_x_max_q;
    r_x_start_d   = r_x_start_q;
    r_x_end_d     = r_x_end_q;
    r_y_min_d     = r_y_min_q;
    r_y_max_d     = r_y_max_q;
    r_z_max_d     = r_z_max_q;
    r_len_d       = r_len_q;
    r_round_idx_d = r_round_idx_q;
    r_cfg_err_d   = 1'b0;

    unique case (r_state_q)
      StIdle: begin
        if (i_start && !i_abort) begin
          if (w_cfg_ok) begin
            r_state_d     = StLoad;
            r_dim_d       = i_cfg_dim;
            r_pad_d       = w_pad;
            r_area_d      = {8'd0, i_cfg_dim} * {8'd0, i_cfg_dim};
            r_x_max_d     = w_span[7:0] - 8'd1;
            r_z_max_d     = i_cfg_z_max;
            r_idx_d       = 16'd0;
            r_sx_d        = 8'd0;
            r_sy_d        = 8'd0;
            r_round_idx_d = 16'd0;
          end else begin
            r_cfg_err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        r_x_start_d = r_sx_q;
        r_x_end_d   = w_ex + w_pad2;
        r_y_min_d   = r_sy_q;
        r_y_max_d   = w_ey + w_pad2;
        r_len_d     = w_len;
        r_state_d   = StKick;
      end
      StKick: r_state_d = StRun;
      StRun: begin
        if (i_bcast_done) r_state_d = StDrain;
      end
      StDrain: begin
        if (i_alloc_idle) r_state_d = StNext;
      end
      StNext: begin
        r_idx_d = w_idx_nx;
        if (w_idx_nx == r_area_q) begin
          r_state_d = StFin;
        end else begin
          r_round_idx_d = r_round_idx_q + 16'd1;
          r_sx_d        = w_sx_nx;
          r_sy_d        = r_sy_q + {7'd0, w_sx_wrap};
          r_state_d     = StLoad;
        end
      end
      StFin:   r_state_d = StIdle;
      default: r_state_d = StIdle;
    endcase

    if (i_abort) r_state_d = StIdle;

    // Status outputs are registered copies of the decoded next state
    r_bcast_rst_d = (r_state_d != StRun);
    r_busy_d      = (r_state_d != StIdle);
    r_seq_done_d  = (r_state_d == StFin);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q     <= StIdle;
      r_dim_q       <= 8'd0;
      r_pad_q       <= 2'd0;
      r_area_q      <= 16'd0;
      r_idx_q       <= 16'd0;
      r_sx_q        <= 8'd0;
      r_sy_q        <= 8'd0;
      r_x_max_q     <= 8'd0;
      r_x_start_q   <= 8'd0;
      r_x_end_q     <= 8'd0;
      r_y_min_q     <= 8'd0;
      r_y_max_q     <= 8'd0;
      r_z_max_q     <= 9'd0;
      r_len_q       <= 5'd0;
      r_round_idx_q <= 16'd0;
      r_bcast_rst_q <= 1'b1;
      r_busy_q      <= 1'b0;
      r_seq_done_q  <= 1'b0;
      r_cfg_err_q   <= 1'b0;
    end else begin
      r_state_q     <= r_state_d;
      r_dim_q       <= r_dim_d;
      r_pad_q       <= r_pad_d;
      r_area_q      <= r_area_d;
      r_idx_q       <= r_idx_d;
      r_sx_q        <= r_sx_d;
      r_sy_q        <= r_sy_d;
      r_x_max_q     <= r_x_max_d;
      r_x_start_q   <= r_x_start_d;
      r_x_end_q     <= r_x_end_d;
      r_y_min_q     <= r_y_min_d;
      r_y_max_q     <= r_y_max_d;
      r_z_max_q     <= r_z_max_d;
      r_len_q       <= r_len_d;
      r_round_idx_q <= r_round_idx_d;
      r_bcast_rst_q <= r_bcast_rst_d;
      r_busy_q      <= r_busy_d;
      r_seq_done_q  <= r_seq_done_d;
      r_cfg_err_q   <= r_cfg_err_d;
    end
  end

  assign o_bcast_rst     = r_bcast_rst_q;
  assign o_image_padding = r_pad_q;
  assign o_x_min         = 8'd0;
  assign o_x_max         = r_x_max_q;
  assign o_x_start       = r_x_start_q;
  assign o_x_end         = r_x_end_q;
  assign o_y_min         = r_y_min_q;
  assign o_y_max         = r_y_max_q;
  assign o_z_max         = r_z_max_q;
  assign o_round_len     = r_len_q;
  assign o_round_idx     = r_round_idx_q;
  assign o_busy          = r_busy_q;
  assign o_seq_done      = r_seq_done_q;
  assign o_cfg_err       = r_cfg_err_q;

endmodule

// File: tb/tb_issue_round_sequencer.sv
// Bench for issue_round_sequencer: two instances (4 and 5 allocators) checked against a
// pixel-index model of the round walk, with random handshake timing and configurations.
module tb_issue_round_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, abort, bcast_done, alloc_idle;
  logic [7:0] cfg_dim;
  logic [2:0] cfg_filter;
  logic [8:0] cfg_z_max;
  int         sel;

  logic        bcast_rst [2];
  logic        busy      [2];
  logic        seq_done  [2];
  logic        cfg_err   [2];
  logic [1:0]  pad_o     [2];
  logic [7:0]  x_min     [2];
  logic [7:0]  x_max     [2];
  logic [7:0]  x_start   [2];
  logic [7:0]  x_end     [2];
  logic [7:0]  y_min     [2];
  logic [7:0]  y_max     [2];
  logic [8:0]  z_max     [2];
  logic [4:0]  rlen      [2];
  logic [15:0] ridx      [2];

  int n_cmp = 0;
  int n_err = 0;
  int seq_tot [2] = '{0, 0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    issue_round_sequencer #(.NUM_ALLOC(4 + g)) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_start         (start && (sel == g)),
      .i_abort         (abort),
      .i_cfg_dim       (cfg_dim),
      .i_cfg_filter    (cfg_filter),
      .i_cfg_z_max     (cfg_z_max),
      .i_bcast_done    (bcast_done),
      .i_alloc_idle    (alloc_idle),
      .o_bcast_rst     (bcast_rst[g]),
      .o_image_padding (pad_o[g]),
      .o_x_min         (x_min[g]),
      .o_x_max         (x_max[g]),
      .o_x_start       (x_start[g]),
      .o_x_end         (x_end[g]),
      .o_y_min         (y_min[g]),
      .o_y_max         (y_max[g]),
      .o_z_max         (z_max[g]),
      .o_round_len     (rlen[g]),
      .o_round_idx     (ridx[g]),
      .o_busy          (busy[g]),
      .o_seq_done      (seq_done[g]),
      .o_cfg_err       (cfg_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (seq_done[0]) seq_tot[0] <= seq_tot[0] + 1;
    if (seq_done[1]) seq_tot[1] <= seq_tot[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit model_valid(input int n, input int dim, input int filt);
    return (filt == 1 || filt == 3 || filt == 5) && n <= dim && dim + filt - 1 <= 256;
  endfunction

  task automatic check_reset_outputs(input int s);
    check("rst_bcast_rst", bcast_rst[s], 1);
    check("rst_busy", busy[s], 0);
    check("rst_x_end", x_end[s], 0);
    check("rst_y_max", y_max[s], 0);
    check("rst_round_len", rlen[s], 0);
    check("rst_round_idx", ridx[s], 0);
    check("rst_x_max", x_max[s], 0);
    check("rst_seq_done", seq_done[s], 0);
  endtask

  task automatic bad_cfg(input int s, input int dim, input int filt);
    sel = s; cfg_dim = 8'(dim); cfg_filter = 3'(filt);
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("cfg_err", cfg_err[s], 1);
    check("cfg_err_busy", busy[s], 0);
    @(negedge clk);
    check("cfg_err_pulse", cfg_err[s], 0);
    check("cfg_err_idle", busy[s], 0);
  endtask

  // Round k covers linear pixels k*n .. k*n+len-1; bounds follow from div/mod by dim.
  task automatic run_layer(input int s, input int dim, input int filt, input int zmax,
                           input int hold0, input int abort_rnd, input int rst_rnd);
    int n, pad2, area, rounds, p0, p1, len, t, base, hold;
    n = 4 + s; pad2 = filt - 1; area = dim * dim; rounds = (area + n - 1) / n;
    base = seq_tot[s]; p0 = 0; p1 = 0;
    sel = s; cfg_dim = 8'(dim); cfg_filter = 3'(filt); cfg_z_max = 9'(zmax);
    alloc_idle = 1'b1; bcast_done = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("load_busy", busy[s], 1);
    check("load_bcast_rst", bcast_rst[s], 1);
    check("load_cfg_err", cfg_err[s], 0);
    for (int k = 0; k < rounds; k++) begin
      t = (k == 0) ? 1 : 0;
      while (bcast_rst[s] && t < 20) begin @(negedge clk); t++; end
      if (bcast_rst[s]) begin check("run_timeout", bcast_rst[s], 0); return; end
      if (k == 0) check("start_latency", t, 3);
      p0 = k * n; len = (area - p0 < n) ? area - p0 : n; p1 = p0 + len - 1;
      check("round_idx", ridx[s], k);
      check("x_start", x_start[s], p0 % dim);
      check("x_end", x_end[s], p1 % dim + pad2);
      check("y_min", y_min[s], p0 / dim);
      check("y_max", y_max[s], p1 / dim + pad2);
      check("round_len", rlen[s], len);
      if (k == 0) begin
        check("x_min", x_min[s], 0);
        check("x_max", x_max[s], dim + pad2 - 1);
        check("padding", pad_o[s], pad2 / 2);
        check("z_max", z_max[s], zmax);
      end
      if (k == abort_rnd) begin
        abort = 1'b1; @(negedge clk); abort = 1'b0;
        check("abort_busy", busy[s], 0);
        check("abort_bcast_rst", bcast_rst[s], 1);
        repeat (3) @(negedge clk);
        check("abort_no_seq_done", seq_tot[s] - base, 0);
        return;
      end
      hold = $urandom_range(0, 3);
      repeat (hold) begin
        alloc_idle = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("run_hold", bcast_rst[s], 0);
        check("run_x_start_stable", x_start[s], p0 % dim);
      end
      start = 1'b0; bcast_done = 1'b1; @(negedge clk); bcast_done = 1'b0; alloc_idle = 1'b0;
      check("drain_entry", bcast_rst[s], 1);
      hold = (k == 0) ? hold0 : $urandom_range(0, 3);
      repeat (hold) begin
        @(negedge clk);
        check("drain_bcast_rst", bcast_rst[s], 1);
        check("drain_busy", busy[s], 1);
        check("drain_round_idx", ridx[s], k);
        check("drain_y_max", y_max[s], p1 / dim + pad2);
      end
      if (k == rst_rnd) begin
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(s);
        @(negedge clk); rst_n = 1'b1; alloc_idle = 1'b1;
        return;
      end
      alloc_idle = 1'b1;
    end
    t = 0;
    while (!seq_done[s] && t < 10) begin @(negedge clk); t++; end
    check("seq_done", seq_done[s], 1);
    check("fin_x_start_held", x_start[s], p0 % dim);
    check("fin_y_max_held", y_max[s], p1 / dim + pad2);
    @(negedge clk);
    check("fin_idle", busy[s], 0);
    check("seq_done_pulse", seq_done[s], 0);
    check("seq_done_count", seq_tot[s] - base, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bcast_done = 1'b0; alloc_idle = 1'b1;
    cfg_dim = 8'd0; cfg_filter = 3'd0; cfg_z_max = 9'd0; sel = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n = 1'b1;
    @(negedge clk);

    run_layer(0, 8, 3, 100, 10, -1, -1);
    run_layer(1, 8, 3, 511, 0, -1, -1);

    bad_cfg(0, 8, 4);
    bad_cfg(0, 3, 3);
    bad_cfg(0, 253, 5);
    bad_cfg(1, 4, 1);

    // Largest legal padded width: 252 + 4 = 256
    sel = 0; cfg_dim = 8'd252; cfg_filter = 3'd5;
    start = 1'b1; @(negedge clk); start = 1'b0;
    check("edge_cfg_err", cfg_err[0], 0);
    check("edge_busy", busy[0], 1);
    check("edge_x_max", x_max[0], 255);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    check("edge_abort_busy", busy[0], 0);

    run_layer(0, 8, 3, 7, 0, 2, -1);
    run_layer(0, 4, 1, 3, 0, -1, -1);
    run_layer(0, 6, 5, 9, 0, -1, 1);
    run_layer(0, 4, 1, 3, 0, -1, -1);

    for (int i = 0; i < 12; i++) begin
      int s, dim, filt, arnd;
      s = $urandom_range(0, 1);
      dim = $urandom_range(1, 14);
      filt = (i % 4 == 3) ? $urandom_range(0, 7) : 2 * $urandom_range(0, 2) + 1;
      arnd = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
      if (model_valid(4 + s, dim, filt))
        run_layer(s, dim, filt, $urandom_range(0, 511), $urandom_range(0, 4), arnd, -1);
      else
        bad_cfg(s, dim, filt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
